// File: rtl/move_controller.sv
// Click-driven move sequencer for the 8x8 board: validates source and destination
// through a shared request/grant memory port, writes destination then clears source.
`timescale 1ns/1ps
module move_controller #(
  parameter int COUNT_W     = 10,
  parameter bit WHITE_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               click,
  input  logic [5:0]         square,
  input  logic               square_valid,
  output logic               brd_req,
  input  logic               brd_gnt,
  output logic [5:0]         brd_addr,
  output logic               brd_we,
  output logic [3:0]         brd_wdata,
  input  logic [3:0]         brd_rdata,
  output logic               turn,
  output logic               selected,
  output logic [5:0]         sel_square,
  output logic [3:0]         held_piece,
  output logic               move_done,
  output logic               move_reject,
  output logic [COUNT_W-1:0] move_count
);

  typedef enum logic [3:0] {
    IDLE, RD_SRC, CHK_SRC, HOLD, RD_DST, CHK_DST, WR_DST, WR_SRC, DONE
  } state_t;

  state_t     state_reg;
  logic [5:0] src_reg;
  logic [5:0] dst_reg;
  logic       rd_is_piece;
  logic       rd_is_own;

  // A square holds a piece only when its type field is nonzero.
  assign rd_is_piece = (brd_rdata[2:0] != 3'd0);
  assign rd_is_own   = rd_is_piece && (brd_rdata[3] == turn);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      src_reg     <= '0;
      dst_reg     <= '0;
      brd_req     <= 1'b0;
      brd_addr    <= '0;
      brd_we      <= 1'b0;
      brd_wdata   <= '0;
      turn        <= ~WHITE_FIRST;
      selected    <= 1'b0;
      sel_square  <= '0;
      held_piece  <= '0;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      move_count  <= '0;
    end else begin
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (click && square_valid) begin
            src_reg   <= square;
            brd_req   <= 1'b1;
            brd_we    <= 1'b0;
            brd_addr  <= square;
            state_reg <= RD_SRC;
          end
        end
        RD_SRC: begin
          if (brd_gnt) begin
            brd_req   <= 1'b0;
            state_reg <= CHK_SRC;
          end
        end
        CHK_SRC: begin
          if (rd_is_own) begin
            selected   <= 1'b1;
            sel_square <= src_reg;
            held_piece <= brd_rdata;
            state_reg  <= HOLD;
          end else begin
            move_reject <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        HOLD: begin
          if (click) begin
            if (!square_valid || square == sel_square) begin
              selected  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              dst_reg   <= square;
              brd_req   <= 1'b1;
              brd_we    <= 1'b0;
              brd_addr  <= square;
              state_reg <= RD_DST;
            end
          end
        end
        RD_DST: begin
          if (brd_gnt) begin
            brd_req   <= 1'b0;
            state_reg <= CHK_DST;
          end
        end
        CHK_DST: begin
          if (rd_is_own) begin
            sel_square <= dst_reg;
            held_piece <= brd_rdata;
            state_reg  <= HOLD;
          end else begin
            brd_req   <= 1'b1;
            brd_we    <= 1'b1;
            brd_addr  <= dst_reg;
            brd_wdata <= held_piece;
            state_reg <= WR_DST;
          end
        end
        WR_DST: begin
          // Request stays up: the source clear follows back to back.
          if (brd_gnt) begin
            brd_addr  <= sel_square;
            brd_wdata <= 4'd0;
            state_reg <= WR_SRC;
          end
        end
        WR_SRC: begin
          if (brd_gnt) begin
            brd_req   <= 1'b0;
            brd_we    <= 1'b0;
            move_done <= 1'b1;
            turn      <= ~turn;
            selected  <= 1'b0;
            if (move_count != {COUNT_W{1'b1}})
              move_count <= move_count + 1'b1;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
